// File: rtl/storage_wb_bridge_pkg.sv
// Shared definitions for the storage Wishbone bridge: FSM encoding, SRAM geometry
// and the default window base.
package storage_wb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam int          SRAM_WORD_AW = 9;
    localparam int          BANK_BYTES   = 2048;
    localparam logic [31:0] DEF_BASE_ADR = 32'h0100_0000;

    // Bank index width; a single bank still carries one decode bit.
    function automatic int bank_width(input int blocks);
        return (blocks > 1) ? $clog2(blocks) : 1;
    endfunction

endpackage

// File: rtl/storage_wb_bridge.sv
// Wishbone-classic slave driving the storage block's management SRAM port:
// one request in flight, registered chip-select/write-enable/mask, single-cycle ack or err.
module storage_wb_bridge
    import storage_wb_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = DEF_BASE_ADR,
    parameter int          RAM_BLOCKS = 1,
    parameter int          READ_LAT   = 1
) (
    input  logic                      mgmt_clk,
    input  logic                      mgmt_resetn,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [3:0]                wb_sel_i,
    input  logic [31:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [RAM_BLOCKS-1:0]     mgmt_ena,
    output logic [RAM_BLOCKS-1:0]     mgmt_wen,
    output logic [RAM_BLOCKS*4-1:0]   mgmt_wen_mask,
    output logic [SRAM_WORD_AW-1:0]   mgmt_addr,
    output logic [31:0]               mgmt_wdata,
    input  logic [RAM_BLOCKS*32-1:0]  mgmt_rdata
);

    localparam int BANK_W  = bank_width(RAM_BLOCKS);
    localparam int TAG_LSB = 12 + BANK_W;

    state_t                  state_q, next_state;
    logic [BANK_W-1:0]       bank_q, bank_d, req_bank;
    logic                    we_q, we_d;
    logic                    aborted_q, aborted_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    req, mapped;

    logic [RAM_BLOCKS-1:0]   ena_d, wen_d;
    logic [RAM_BLOCKS*4-1:0] mask_d;
    logic [SRAM_WORD_AW-1:0] addr_d;
    logic [31:0]             wdata_d, dat_d;
    logic                    ack_d, err_d;

    assign req      = wb_cyc_i & wb_stb_i;
    assign req_bank = wb_adr_i[11 +: BANK_W];
    assign mapped   = (wb_adr_i[31:TAG_LSB] == BASE_ADR[31:TAG_LSB])
                   && (int'(req_bank) < RAM_BLOCKS);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge mgmt_clk or negedge mgmt_resetn) begin
        if (!mgmt_resetn) state_q <= ST_IDLE;
        else              state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE:  if (req) next_state = mapped ? ST_ISSUE : ST_ERR;
            ST_ISSUE: next_state = we_q ? (wb_cyc_i ? ST_ACK : ST_IDLE) : ST_WAIT;
            ST_WAIT:  if (cnt_q == 2'd0)
                          next_state = (aborted_q || !wb_cyc_i) ? ST_IDLE : ST_ACK;
            ST_ACK,
            ST_ERR:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; chip select is only ever low for the ISSUE cycle.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        ena_d     = '1;
        wen_d     = '1;
        mask_d    = '0;
        addr_d    = mgmt_addr;
        wdata_d   = mgmt_wdata;
        dat_d     = wb_dat_o;
        bank_d    = bank_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        ack_d     = (next_state == ST_ACK);
        err_d     = (next_state == ST_ERR);
        case (state_q)
            ST_IDLE: if (next_state == ST_ISSUE) begin
                bank_d          = req_bank;
                we_d            = wb_we_i;
                addr_d          = wb_adr_i[10:2];
                wdata_d         = wb_dat_i;
                aborted_d       = 1'b0;
                ena_d[req_bank] = 1'b0;
                if (wb_we_i) begin
                    wen_d[req_bank]            = 1'b0;
                    mask_d[req_bank*4 +: 4]    = wb_sel_i;
                end
            end
            ST_ISSUE: begin
                cnt_d     = 2'(READ_LAT - 1);
                aborted_d = !wb_cyc_i;
            end
            ST_WAIT: begin
                if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
                aborted_d = aborted_q | !wb_cyc_i;
                if (next_state == ST_ACK) dat_d = mgmt_rdata[bank_q*32 +: 32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge mgmt_clk or negedge mgmt_resetn) begin
        if (!mgmt_resetn) begin
            mgmt_ena      <= '1;
            mgmt_wen      <= '1;
            mgmt_wen_mask <= '0;
            mgmt_addr     <= '0;
            mgmt_wdata    <= '0;
            wb_dat_o      <= '0;
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
            bank_q        <= '0;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            aborted_q     <= 1'b0;
        end else begin
            mgmt_ena      <= ena_d;
            mgmt_wen      <= wen_d;
            mgmt_wen_mask <= mask_d;
            mgmt_addr     <= addr_d;
            mgmt_wdata    <= wdata_d;
            wb_dat_o      <= dat_d;
            wb_ack_o      <= ack_d;
            wb_err_o      <= err_d;
            bank_q        <= bank_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            aborted_q     <= aborted_d;
        end
    end

endmodule

// File: tb/tb_storage_wb_bridge.sv
// Self-checking bench for storage_wb_bridge: SRAM behavioural model on the
// management port plus a word-level reference memory and spec-derived timing.
module tb_storage_wb_bridge;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int          RB   = 1;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_resetn = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [RB-1:0]    mgmt_ena, mgmt_wen;
    logic [RB*4-1:0]  mgmt_wen_mask;
    logic [8:0]       mgmt_addr;
    logic [31:0]      mgmt_wdata;
    logic [RB*32-1:0] mgmt_rdata;

    int tests_run = 0;
    int fails     = 0;

    always #5 mgmt_clk = ~mgmt_clk;

    storage_wb_bridge #(.BASE_ADR(BASE), .RAM_BLOCKS(RB), .READ_LAT(1)) dut (
        .mgmt_clk(mgmt_clk), .mgmt_resetn(mgmt_resetn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .mgmt_ena(mgmt_ena), .mgmt_wen(mgmt_wen), .mgmt_wen_mask(mgmt_wen_mask),
        .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata), .mgmt_rdata(mgmt_rdata)
    );

    // SRAM behavioural model: one-edge read latency, byte-masked writes.
    logic [31:0] sram [512];
    logic [31:0] sram_q = '0;
    always @(posedge mgmt_clk) begin
        if (mgmt_ena[0] === 1'b0) begin
            if (mgmt_wen[0] === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (mgmt_wen_mask[b]) sram[mgmt_addr][b*8 +: 8] <= mgmt_wdata[b*8 +: 8];
            end else begin
                sram_q <= sram[mgmt_addr];
            end
        end
    end
    assign mgmt_rdata = sram_q;

    // Reference: what each word should hold, and what wb_dat_o last returned.
    logic [31:0] ref_mem [512];
    logic [31:0] last_rd = '0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic bit in_window(input logic [31:0] adr);
        return ((adr >> 13) == (BASE >> 13)) && (int'((adr >> 11) & 32'd1) < RB);
    endfunction

    // One complete transaction with timing, SRAM-port and data checks.
    task automatic do_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input string tag);
        bit          mapped;
        int          word, exp_ack, exp_err, ack_k, err_k, ack_n, err_n, low_cnt, both;
        logic [31:0] rd;
        mapped  = in_window(adr);
        word    = int'((adr >> 2) & 32'd511);
        exp_ack = !mapped ? 0 : (we ? 2 : 3);
        exp_err = mapped ? 0 : 1;
        ack_k = 0; err_k = 0; ack_n = 0; err_n = 0; low_cnt = 0; both = 0; rd = '0;
        @(negedge mgmt_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        for (int k = 1; k <= 8; k++) begin
            @(negedge mgmt_clk);
            if (k == 1 && mapped) begin
                tests_run++;
                if (mgmt_ena !== 1'b0) begin fails++; $display("FAIL %s ena: got %b expected 0", tag, mgmt_ena); end
                tests_run++;
                if (mgmt_wen !== (we ? 1'b0 : 1'b1)) begin fails++; $display("FAIL %s wen: got %b expected %b", tag, mgmt_wen, !we); end
                tests_run++;
                if (mgmt_addr !== 9'(word)) begin fails++; $display("FAIL %s addr: got %h expected %h", tag, mgmt_addr, 9'(word)); end
                if (we) begin
                    tests_run++;
                    if (mgmt_wen_mask !== sel) begin fails++; $display("FAIL %s mask: got %h expected %h", tag, mgmt_wen_mask, sel); end
                    tests_run++;
                    if (mgmt_wdata !== dat) begin fails++; $display("FAIL %s wdata: got %h expected %h", tag, mgmt_wdata, dat); end
                end
            end
            if (mgmt_ena !== 1'b1) low_cnt++;
            if (wb_ack_o === 1'b1 && wb_err_o === 1'b1) both++;
            if (wb_ack_o === 1'b1) begin
                ack_n++;
                if (ack_k == 0) begin ack_k = k; rd = wb_dat_o; end
            end
            if (wb_err_o === 1'b1) begin
                err_n++;
                if (err_k == 0) err_k = k;
            end
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tests_run++;
        if (ack_k != exp_ack || ack_n != (exp_ack != 0 ? 1 : 0)) begin
            fails++; $display("FAIL %s ack: got cycle %0d count %0d expected cycle %0d", tag, ack_k, ack_n, exp_ack);
        end
        tests_run++;
        if (err_k != exp_err || err_n != exp_err) begin
            fails++; $display("FAIL %s err: got cycle %0d count %0d expected cycle %0d", tag, err_k, err_n, exp_err);
        end
        tests_run++;
        if (low_cnt != (mapped ? 1 : 0) || both != 0) begin
            fails++; $display("FAIL %s select: got %0d low cycles (ack&err %0d) expected %0d", tag, low_cnt, both, mapped ? 1 : 0);
        end
        if (mapped && !we) begin
            last_rd = ref_mem[word];
            tests_run++;
            if (rd !== last_rd) begin fails++; $display("FAIL %s rdata: got %h expected %h", tag, rd, last_rd); end
        end else begin
            tests_run++;
            if (wb_dat_o !== last_rd) begin fails++; $display("FAIL %s dat_hold: got %h expected %h", tag, wb_dat_o, last_rd); end
        end
        if (mapped && we) ref_mem[word] = merge(ref_mem[word], dat, sel);
    endtask

    task automatic test_reset();
        int ack_seen;
        repeat (3) @(negedge mgmt_clk);
        tests_run++;
        if (mgmt_ena !== '1 || mgmt_wen !== '1) begin fails++; $display("FAIL reset_sel: got ena %b wen %b expected all 1", mgmt_ena, mgmt_wen); end
        tests_run++;
        if (mgmt_wen_mask !== '0 || mgmt_addr !== '0 || mgmt_wdata !== '0) begin
            fails++; $display("FAIL reset_port: got mask %h addr %h wdata %h expected 0", mgmt_wen_mask, mgmt_addr, mgmt_wdata);
        end
        tests_run++;
        if (wb_dat_o !== '0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
            fails++; $display("FAIL reset_wb: got dat %h ack %b err %b expected 0", wb_dat_o, wb_ack_o, wb_err_o);
        end
        mgmt_resetn = 1'b1;
        // Reset in the middle of a read.
        @(negedge mgmt_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0100_0010; wb_sel_i = 4'hF;
        @(negedge mgmt_clk);
        tests_run++;
        if (mgmt_ena !== 1'b0) begin fails++; $display("FAIL reset_pre: got ena %b expected 0", mgmt_ena); end
        mgmt_resetn = 1'b0;
        #1;
        tests_run++;
        if (mgmt_ena !== '1 || mgmt_wen !== '1) begin fails++; $display("FAIL reset_async: got ena %b wen %b expected all 1", mgmt_ena, mgmt_wen); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(negedge mgmt_clk);
        mgmt_resetn = 1'b1;
        ack_seen = 0;
        repeat (6) begin
            @(negedge mgmt_clk);
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1 || mgmt_ena !== '1) ack_seen++;
        end
        tests_run++;
        if (ack_seen != 0) begin fails++; $display("FAIL reset_quiet: got %0d active cycles expected 0", ack_seen); end
        last_rd = '0;
    endtask

    task automatic test_write_read();
        do_req(1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 4'hF, "write");
        do_req(1'b0, 32'h0100_0010, 32'h0, 4'hF, "readback");
        do_req(1'b1, 32'h0100_0010, 32'h0000_5500, 4'b0010, "partial_wr");
        do_req(1'b0, 32'h0100_0010, 32'h0, 4'hF, "partial_rd");
        tests_run++;
        if (last_rd !== 32'hDEAD_55EF) begin fails++; $display("FAIL partial_model: got %h expected DEAD55EF", last_rd); end
        do_req(1'b1, 32'h0100_0010, 32'hFFFF_FFFF, 4'h0, "zero_sel_wr");
        do_req(1'b0, 32'h0100_0010, 32'h0, 4'hF, "zero_sel_rd");
    endtask

    task automatic test_unmapped();
        do_req(1'b0, 32'h0100_0800, 32'h0, 4'hF, "unmapped_bank");
        do_req(1'b1, 32'h0200_0010, 32'h1234_5678, 4'hF, "unmapped_win");
        do_req(1'b0, 32'h0100_0010, 32'h0, 4'hF, "after_unmapped");
    endtask

    task automatic test_abort();
        int act;
        @(negedge mgmt_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0100_0040; wb_sel_i = 4'hF;
        repeat (2) @(negedge mgmt_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        act = 0;
        repeat (6) begin
            @(negedge mgmt_clk);
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) act++;
        end
        tests_run++;
        if (act != 0) begin fails++; $display("FAIL abort: got %0d ack/err cycles expected 0", act); end
        do_req(1'b0, 32'h0100_0010, 32'h0, 4'hF, "after_abort");
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        logic [31:0] ra, rb;
        do_req(1'b1, 32'h0100_0020, 32'h1111_2222, 4'hF, "b2b_wa");
        do_req(1'b1, 32'h0100_0024, 32'h3333_4444, 4'hF, "b2b_wb");
        k1 = 0; k2 = 0; ra = '0; rb = '0;
        @(negedge mgmt_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0100_0020; wb_sel_i = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            @(negedge mgmt_clk);
            if (wb_ack_o === 1'b1) begin
                if (k1 == 0) begin
                    k1 = k; ra = wb_dat_o; wb_adr_i = 32'h0100_0024;
                end else if (k2 == 0) begin
                    k2 = k; rb = wb_dat_o; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
                end
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tests_run++;
        if (k1 != 3 || k2 != 7) begin fails++; $display("FAIL b2b_timing: got acks at %0d,%0d expected 3,7", k1, k2); end
        tests_run++;
        if (ra !== ref_mem[8] || rb !== ref_mem[9]) begin
            fails++; $display("FAIL b2b_data: got %h,%h expected %h,%h", ra, rb, ref_mem[8], ref_mem[9]);
        end
        last_rd = ref_mem[9];
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] adr;
            int kind;
            kind = int'($urandom_range(0, 9));
            adr  = BASE | ($urandom_range(0, 511) << 2);
            if (kind == 0) adr = adr | 32'h0000_0800;
            else if (kind == 1) adr = 32'h0300_0000 | adr[11:0];
            do_req(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        test_reset();
        test_write_read();
        test_unmapped();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
